alu_entry_sequencer: RTL and testbench

//   Front-panel controller for the ALU. Takes debounced button levels and switch

---
 rtl/alu_entry_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_entry_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_entry_sequencer.sv
// Front-panel sequencer for the ALU. It captures operand A, operand B and the opcode from
// the switches on button presses, starts the ALU, waits for done or a timeout, and shows the result.
module alu_entry_sequencer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned OP_WIDTH = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_next,
  input  logic                btn_back,
  input  logic [WIDTH-1:0]    sw,
  input  logic                alu_done,
  input  logic [WIDTH-1:0]    alu_result,
  output logic [WIDTH-1:0]    op_a,
  output logic [WIDTH-1:0]    op_b,
  output logic [OP_WIDTH-1:0] opcode,
  output logic                alu_start,
  output logic [WIDTH-1:0]    result,
  output logic                err,
  output logic                busy,
  output logic [2:0]          state
);

  localparam int unsigned   CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          next_prev;
  logic          back_prev;
  logic          next_press;
  logic          back_press;
  logic          next_evt;
  logic          back_evt;
  logic [CW-1:0] cnt;

  logic cap_a;
  logic cap_b;
  logic cap_op;
  logic enter_exec;
  logic ld_result;
  logic set_err;
  logic clr_err;

  // A press is a rising edge of the level. Simultaneous presses cancel each other.
  assign next_press = btn_next & ~next_prev;
  assign back_press = btn_back & ~back_prev;
  assign next_evt   = next_press & ~back_press;
  assign back_evt   = back_press & ~next_press;

  always_comb begin
    state_d    = state_q;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    cap_op     = 1'b0;
    enter_exec = 1'b0;
    ld_result  = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    case (state_q)
      S_A: begin
        if (next_evt) begin
          cap_a   = 1'b1;
          state_d = S_B;
        end
      end
      S_B: begin
        if (next_evt) begin
          cap_b   = 1'b1;
          state_d = S_OP;
        end else if (back_evt) begin
          state_d = S_A;
        end
      end
      S_OP: begin
        if (next_evt) begin
          cap_op     = 1'b1;
          enter_exec = 1'b1;
          state_d    = S_EXEC;
        end else if (back_evt) begin
          state_d = S_B;
        end
      end
      S_EXEC: begin
        // If done arrives on the terminal count, done takes priority over the timeout.
        if (alu_done) begin
          ld_result = 1'b1;
          clr_err   = 1'b1;
          state_d   = S_SHOW;
        end else if (cnt == CNT_LAST) begin
          set_err = 1'b1;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (next_evt) begin
          clr_err = 1'b1;
          state_d = S_A;
        end else if (back_evt) begin
          state_d = S_OP;
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_A;
      next_prev <= 1'b1;
      back_prev <= 1'b1;
      op_a      <= '0;
      op_b      <= '0;
      opcode    <= '0;
      result    <= '0;
      err       <= 1'b0;
      alu_start <= 1'b0;
      cnt       <= '0;
    end else begin
      state_q   <= state_d;
      next_prev <= btn_next;
      back_prev <= btn_back;
      alu_start <= enter_exec;
      if (cap_a)     op_a   <= sw;
      if (cap_b)     op_b   <= sw;
      if (cap_op)    opcode <= sw[OP_WIDTH-1:0];
      if (ld_result) result <= alu_result;
      if (set_err)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;
      if (enter_exec)
        cnt <= '0;
      else if (state_q == S_EXEC && cnt != CNT_LAST)
        cnt <= cnt + 1'b1;
    end
  end

  assign busy  = (state_q == S_EXEC);
  assign state = state_q;

endmodule

// File: tb/tb_alu_entry_sequencer.sv
// Directed testbench for alu_entry_sequencer. Each check uses an immediate assertion
// against a hand-computed expected value.
module tb_alu_entry_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_next;
  logic       btn_back;
  logic [7:0] sw;
  logic       alu_done;
  logic [7:0] alu_result;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [3:0] opcode;
  logic       alu_start;
  logic [7:0] result;
  logic       err;
  logic       busy;
  logic [2:0] state;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  alu_entry_sequencer #(
    .WIDTH   (8),
    .OP_WIDTH(4),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_next  (btn_next),
    .btn_back  (btn_back),
    .sw        (sw),
    .alu_done  (alu_done),
    .alu_result(alu_result),
    .op_a      (op_a),
    .op_b      (op_b),
    .opcode    (opcode),
    .alu_start (alu_start),
    .result    (result),
    .err       (err),
    .busy      (busy),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_next(input logic [7:0] val);
    sw       = val;
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    tick();
  endtask

  task automatic press_back();
    btn_back = 1'b1;
    tick();
    btn_back = 1'b0;
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    btn_next   = 1'b1;
    btn_back   = 1'b0;
    sw         = 8'hAA;
    alu_done   = 1'b0;
    alu_result = 8'h00;

    // 1: reset while next is held, then release it without a press being seen
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("held_state", 32'(state), 32'd0);
    check("held_op_a", 32'(op_a), 32'h00);
    btn_next = 1'b0;
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", {8'(op_a), 8'(op_b), 4'(opcode), 8'(result), 1'(alu_start), 1'(err), 1'(busy), 1'b0},
          32'h0);

    // 2: enter operands and opcode
    press_next(8'h12);
    check("a_cap", 32'(op_a), 32'h12);
    check("a_state", 32'(state), 32'd1);
    press_next(8'h34);
    check("b_cap", 32'(op_b), 32'h34);
    check("b_state", 32'(state), 32'd2);
    sw       = 8'h05;
    btn_next = 1'b1;
    tick();
    check("op_cap", 32'(opcode), 32'h5);
    check("exec_state", 32'(state), 32'd3);
    check("start_hi", 32'(alu_start), 32'd1);
    check("busy_hi", 32'(busy), 32'd1);
    btn_next = 1'b0;
    tick();
    check("start_lo", 32'(alu_start), 32'd0);

    // 3: done arrives 3 cycles after start
    tick();
    alu_done   = 1'b1;
    alu_result = 8'h46;
    tick();
    alu_done = 1'b0;
    check("res_46", 32'(result), 32'h46);
    check("res_err", 32'(err), 32'd0);
    check("show_state", 32'(state), 32'd4);
    check("show_busy", 32'(busy), 32'd0);
    alu_done   = 1'b1;
    alu_result = 8'h99;
    tick();
    alu_done = 1'b0;
    check("done_ignored", 32'(result), 32'h46);

    // 6a: from SHOW, go back to change only the opcode and run again
    press_back();
    check("show_back", 32'(state), 32'd2);
    sw       = 8'h03;
    btn_next = 1'b1;
    tick();
    check("rerun_op", 32'(opcode), 32'h3);
    check("rerun_start", 32'(alu_start), 32'd1);
    check("rerun_ab", {16'h0, op_a, op_b}, 32'h1234);
    btn_next = 1'b0;

    // 4a: timeout, err must rise exactly 16 cycles after entering EXEC
    repeat (15) tick();
    check("to_pre_state", 32'(state), 32'd3);
    check("to_pre_err", 32'(err), 32'd0);
    tick();
    check("to_state", 32'(state), 32'd4);
    check("to_err", 32'(err), 32'd1);
    check("to_result", 32'(result), 32'h46);

    press_next(8'h00);
    check("show_next", 32'(state), 32'd0);
    check("err_clr", 32'(err), 32'd0);
    check("ops_kept", {8'h0, op_a, op_b, 4'h0, opcode}, 32'h00123403);
    press_back();
    check("a_back_ign", 32'(state), 32'd0);

    // 5: holding next advances only once
    sw       = 8'h12;
    btn_next = 1'b1;
    repeat (100) tick();
    btn_next = 1'b0;
    tick();
    check("hold_once", 32'(state), 32'd1);
    press_next(8'h34);
    press_back();
    check("op_back", 32'(state), 32'd1);
    press_next(8'h34);
    btn_next = 1'b1;
    btn_back = 1'b1;
    tick();
    btn_next = 1'b0;
    btn_back = 1'b0;
    tick();
    check("both_ign", 32'(state), 32'd2);

    // 4b: done on the terminal cycle wins over the timeout
    sw       = 8'h05;
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    tick();
    repeat (14) tick();
    check("term_pre", 32'(state), 32'd3);
    alu_done   = 1'b1;
    alu_result = 8'h5A;
    tick();
    alu_done = 1'b0;
    check("term_state", 32'(state), 32'd4);
    check("term_err", 32'(err), 32'd0);
    check("term_res", 32'(result), 32'h5A);

    // 6b: reset during EXEC, then a late done is ignored
    press_back();
    sw       = 8'h09;
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    check("abort_pre", 32'(state), 32'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", 32'(state), 32'd0);
    check("abort_outs", {8'(op_a), 8'(op_b), 4'(opcode), 8'(result), 1'(alu_start), 1'(err), 1'(busy), 1'b0},
          32'h0);
    alu_done   = 1'b1;
    alu_result = 8'h77;
    tick();
    alu_done = 1'b0;
    check("late_done_res", 32'(result), 32'h00);
    check("late_done_state", 32'(state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
